// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit.
// Moore FSM that sequences fetch, decode and the per-instruction execute and
// write-back steps for lw, sw, R-type, beq, addi and j. The only Mealy-style
// signal is pcen, which folds the ALU zero flag into the branch decision.
module mips_mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       pcwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] next_state;
    logic [3:0] dec_state;

    // State register: synchronous reset always returns to FETCH, even mid-instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every state is left after exactly one cycle
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    next_state = MEMRD;
                end else if (op == OP_SW) begin
                    next_state = MEMWR;
                end else begin
                    next_state = FETCH;
                end
            end
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // While in reset the datapath controls show the FETCH decode
    assign dec_state = rst_n ? state : FETCH;

    // Output decode per state; write strobes are suppressed while reset is held
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        branch   = 1'b0;
        pcwrite  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (dec_state)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_mc_control.sv
// Testbench for mips_mc_control: directed instruction runs, reset checks and
// randomized instruction streams compared against a sequence-level model.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, branch, pcwrite, pcen;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;
    logic [14:0] ctrl_bus;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Expected control word per state:
    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,branch,pcwrite,alusrcb,pcsrc,aluop}
    logic [14:0] ctrl_tab [16];

    mips_mc_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .zero     (zero),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .branch   (branch),
        .pcwrite  (pcwrite),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .pcen     (pcen),
        .state    (state)
    );

    assign ctrl_bus = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                       alusrca, branch, pcwrite, alusrcb, pcsrc, aluop};

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_pcen(input int st, input logic z);
        if (st == 0 || st == 11) return 1'b1;
        if (st == 8) return z;
        return 1'b0;
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return (o == OP_LW || o == OP_SW || o == OP_RTYPE ||
                o == OP_BEQ || o == OP_ADDI || o == OP_J);
    endfunction

    // Run one instruction from FETCH; op switches to alt_op once MEMADR is reached.
    // zmode: 0/1 holds zero at that value, 2 randomizes it each cycle.
    task automatic applyStimulus(input logic [5:0] op_i, input logic [5:0] alt_op, input int zmode);
        int seq[$];
        seq.push_back(0);
        seq.push_back(1);
        case (op_i)
            OP_LW, OP_SW: begin
                seq.push_back(2);
                if (alt_op == OP_LW) begin
                    seq.push_back(3);
                    seq.push_back(4);
                end else if (alt_op == OP_SW) begin
                    seq.push_back(5);
                end
            end
            OP_RTYPE: begin seq.push_back(6); seq.push_back(7); end
            OP_BEQ:   seq.push_back(8);
            OP_ADDI:  begin seq.push_back(9); seq.push_back(10); end
            OP_J:     seq.push_back(11);
            default:  ;
        endcase
        foreach (seq[i]) begin
            op   = (i >= 2) ? alt_op : op_i;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            @(negedge clk);
            checkOutput($sformatf("state op=%b step%0d", op_i, i), 32'(state), 32'(seq[i]));
            checkOutput($sformatf("ctrl s%0d", seq[i]), 32'(ctrl_bus), 32'(ctrl_tab[seq[i]]));
            checkOutput($sformatf("pcen s%0d z=%0b", seq[i], zero), 32'(pcen), 32'(exp_pcen(seq[i], zero)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] rop;
        for (int i = 0; i < 16; i++) ctrl_tab[i] = 15'b0;
        ctrl_tab[0]  = {9'b001000001, 2'b01, 2'b00, 2'b00};
        ctrl_tab[1]  = {9'b000000000, 2'b11, 2'b00, 2'b00};
        ctrl_tab[2]  = {9'b000000100, 2'b10, 2'b00, 2'b00};
        ctrl_tab[3]  = {9'b100000000, 2'b00, 2'b00, 2'b00};
        ctrl_tab[4]  = {9'b000011000, 2'b00, 2'b00, 2'b00};
        ctrl_tab[5]  = {9'b110000000, 2'b00, 2'b00, 2'b00};
        ctrl_tab[6]  = {9'b000000100, 2'b00, 2'b00, 2'b10};
        ctrl_tab[7]  = {9'b000101000, 2'b00, 2'b00, 2'b00};
        ctrl_tab[8]  = {9'b000000110, 2'b00, 2'b01, 2'b01};
        ctrl_tab[9]  = {9'b000000100, 2'b10, 2'b00, 2'b00};
        ctrl_tab[10] = {9'b000001000, 2'b00, 2'b00, 2'b00};
        ctrl_tab[11] = {9'b000000001, 2'b00, 2'b10, 2'b00};

        // Power-on reset
        rst_n = 1'b0;
        op    = OP_RTYPE;
        zero  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset state", 32'(state), 32'd0);
        @(negedge clk);
        checkOutput("reset irwrite", 32'(irwrite), 32'd0);
        checkOutput("reset pcwrite", 32'(pcwrite), 32'd0);
        checkOutput("reset pcen", 32'(pcen), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("release irwrite", 32'(irwrite), 32'd1);
        checkOutput("release pcen", 32'(pcen), 32'd1);
        checkOutput("release alusrcb", 32'(alusrcb), 32'd1);

        // Directed instruction runs
        applyStimulus(OP_LW, OP_LW, 2);
        applyStimulus(OP_BEQ, OP_BEQ, 1);
        applyStimulus(OP_BEQ, OP_BEQ, 0);
        applyStimulus(OP_SW, OP_SW, 2);
        applyStimulus(6'b111111, 6'b111111, 1);
        applyStimulus(OP_J, OP_J, 0);
        applyStimulus(OP_ADDI, OP_ADDI, 2);
        applyStimulus(OP_RTYPE, OP_RTYPE, 1);
        applyStimulus(OP_LW, OP_RTYPE, 1);
        applyStimulus(OP_SW, OP_LW, 0);

        // Reset in the middle of an R-type instruction
        op   = OP_RTYPE;
        zero = 1'b1;
        @(negedge clk);
        checkOutput("mid state0", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("mid state1", 32'(state), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("mid state6", 32'(state), 32'd6);
        rst_n = 1'b0;
        #1;
        checkOutput("mid rst strobes", 32'({memwrite, irwrite, regwrite, pcwrite, branch, pcen}), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid rst state", 32'(state), 32'd0);
        checkOutput("mid rst strobes2", 32'({memwrite, irwrite, regwrite, pcwrite, branch, pcen}), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("mid release irwrite", 32'(irwrite), 32'd1);
        checkOutput("mid release pcwrite", 32'(pcwrite), 32'd1);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_RTYPE;
                3: rop = OP_BEQ;
                4: rop = OP_ADDI;
                5: rop = OP_J;
                default: begin
                    rop = 6'($urandom_range(0, 63));
                    while (is_legal(rop)) rop = 6'($urandom_range(0, 63));
                end
            endcase
            if ((rop == OP_LW || rop == OP_SW) && $urandom_range(0, 3) == 0) begin
                applyStimulus(rop, 6'($urandom_range(0, 63)), 2);
            end else begin
                applyStimulus(rop, rop, 2);
            end
        end

        @(negedge clk);
        checkOutput("final state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-003 SHALL have port op, input, 6 bits: opcode field instr[31:26] from the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag, valid in the BEQEX state.
REQ-005 SHALL have the following 1-bit Moore outputs: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, branch, pcwrite.
REQ-006 SHALL have port alusrcb, output, 2 bits: ALU B source select (00=B, 01=const 4, 10=sign_imm, 11=sign_imm_shift2).
REQ-007 SHALL have ports pcsrc and aluop, output, 2 bits each: pcsrc 00=ALU result, 01=ALUOut, 10=jump target; aluop 00=add, 01=sub, 10=funct-decoded.
REQ-008 SHALL have port pcen, output, 1 bit: pcen = pcwrite | (branch & zero).
REQ-009 SHALL have port state, output, 4 bits: current state encoding, for debug and verification.

Function
REQ-010 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-011 SHALL advance exactly one state per clk edge; no state holds for more than one cycle.
REQ-012 SHALL transition FETCH->DECODE unconditionally.
REQ-013 SHALL transition from DECODE on op: 100011 (lw) or 101011 (sw) ->MEMADR; 000000 (R-type) ->RTYPEEX; 000100 (beq) ->BEQEX; 001000 (addi) ->ADDIEX; 000010 (j) ->JEX; any other op ->FETCH (illegal opcode skipped, no write strobe asserted).
REQ-014 SHALL transition from MEMADR to MEMRD if op=lw and to MEMWR if op=sw; op is sampled again in MEMADR, and any other value ->FETCH.
REQ-015 SHALL make the transitions MEMRD->MEMWB, RTYPEEX->RTYPEWB and ADDIEX->ADDIWB.
REQ-016 SHALL make the transitions MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX ->FETCH.
REQ-017 SHALL drive all outputs not listed for a state to 0 in that state.
REQ-018 SHALL drive FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-019 SHALL drive DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target computed into ALUOut).
REQ-020 SHALL drive MEMADR: alusrca=1, alusrcb=10, aluop=00.
REQ-021 SHALL drive MEMRD: iord=1.
REQ-022 SHALL drive MEMWB: regdst=0, memtoreg=1, regwrite=1.
REQ-023 SHALL drive MEMWR: iord=1, memwrite=1.
REQ-024 SHALL drive RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
REQ-025 SHALL drive RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-026 SHALL drive BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-027 SHALL drive ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-028 SHALL drive ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-029 SHALL drive JEX: pcsrc=10, pcwrite=1.
REQ-030 SHALL produce pcen combinationally, in the same cycle as zero; pcen is 1 in FETCH and JEX, equals zero in BEQEX, and is 0 in all other states.
REQ-031 SHALL decode any unused state encoding (12-15) to all-zero outputs, with next state FETCH.
REQ-032 SHALL have per-instruction latency, counting FETCH: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal op 2 cycles.

Reset
REQ-033 SHALL load state=FETCH on a clk edge with rst_n=0, whatever the current state, including mid-instruction.
REQ-034 SHALL force memwrite, irwrite, regwrite, pcwrite, branch and pcen to 0 combinationally while rst_n=0; the other outputs then show the FETCH decode.
REQ-035 SHALL output the full FETCH decode (irwrite=1, pcwrite=1, pcen=1, alusrcb=01) in the first cycle after rst_n rises.

Verification
REQ-036 SHALL be tested with: reset, then op=100011 held -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; alusrcb sequence 01,11,10,00,00.
REQ-037 SHALL be tested with: op=000100 and zero=1 in BEQEX -> pcen=1, pcsrc=01, alusrcb=00, aluop=01; repeat with zero=0 -> pcen=0; next state 0 in both cases.
REQ-038 SHALL be tested with: op=101011 -> states 0,1,2,5,0; memwrite=1 and iord=1 only in state 5; regwrite=0 throughout.
REQ-039 SHALL be tested with: op=111111 -> states 0,1,0; no memwrite, regwrite or pcen in state 1.
REQ-040 SHALL be tested with: rst_n=0 applied in state 6 (RTYPEEX) -> state=0 after the next edge; write strobes 0 while rst_n=0; irwrite=1 in the first cycle after release.
REQ-041 SHALL be tested with: op=000010 -> states 0,1,11,0; pcsrc=10 and pcen=1 in state 11; op=001000 -> states 0,1,9,10,0 with regdst=0 and regwrite=1 in state 10.
